// File: rtl/y86_dmem_seq_unit.sv
// Multi-cycle Y86-64 memory stage: decodes icode, then moves one byte per cycle
// between an internal little-endian byte memory and valM/write data.
module y86_dmem_seq_unit #(
  parameter int MEM_BYTES  = 1024,
  parameter int WORD_BYTES = 8,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int SW = CW + 3;
  localparam int WW = 8 * WORD_BYTES;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     addr_reg;
  logic [WW-1:0]     wdata_reg;
  logic              rd_reg;
  logic [CW-1:0]     cnt_reg;
  logic [WW-1:0]     asm_reg, asm_next;
  logic [DATA_W-1:0] valm_reg;
  logic              err_reg;

  logic              is_mem, is_rd, use_vala_addr, use_valp_data;
  logic [DATA_W-1:0] req_addr, req_data;
  logic [DATA_W:0]   addr_end;
  logic              addr_ok;
  logic              last_byte;
  logic [AW-1:0]     cur_addr;
  logic [SW-1:0]     bit_sel;
  logic              wr_en;
  logic [7:0]        wr_byte, rd_byte;
  logic [7:0]        mem_rd [MEM_BYTES];

  always_comb begin
    is_mem        = 1'b0;
    is_rd         = 1'b0;
    use_vala_addr = 1'b0;
    use_valp_data = 1'b0;
    case (icode)
      4'h4: is_mem = 1'b1;
      4'h5: begin is_mem = 1'b1; is_rd = 1'b1; end
      4'h8: begin is_mem = 1'b1; use_valp_data = 1'b1; end
      4'h9: begin is_mem = 1'b1; is_rd = 1'b1; use_vala_addr = 1'b1; end
      4'hA: is_mem = 1'b1;
      4'hB: begin is_mem = 1'b1; is_rd = 1'b1; use_vala_addr = 1'b1; end
      default: ;
    endcase
  end

  assign req_addr = use_vala_addr ? valA : valE;
  assign req_data = use_valp_data ? valP : valA;
  // One extra bit so addresses near the top of the DATA_W range cannot wrap into range.
  assign addr_end = {1'b0, req_addr} + (DATA_W+1)'(WORD_BYTES);
  assign addr_ok  = (addr_end <= (DATA_W+1)'(MEM_BYTES));

  assign last_byte = (cnt_reg == CW'(WORD_BYTES - 1));
  assign cur_addr  = addr_reg + AW'(cnt_reg);
  assign bit_sel   = {cnt_reg, 3'b000};
  assign wr_byte   = wdata_reg[bit_sel +: 8];
  // A reset in the middle of a write suppresses the byte of that cycle.
  assign wr_en     = (state_reg == ACCESS) && !rd_reg && !reset;
  assign rd_byte   = mem_rd[cur_addr];

  // Byte storage with power-up contents byte i = i mod 256; never cleared by reset.
  for (genvar gi = 0; gi < MEM_BYTES; gi++) begin : g_mem
    logic [7:0] byte_reg = 8'(gi % 256);
    always_ff @(posedge clk) begin
      if (wr_en && (cur_addr == AW'(gi)))
        byte_reg <= wr_byte;
    end
    assign mem_rd[gi] = byte_reg;
  end

  always_comb begin
    asm_next = asm_reg;
    asm_next[bit_sel +: 8] = rd_byte;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (is_mem && addr_ok) ? ACCESS : DONE;
      ACCESS:  if (last_byte) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= 1'b0;
      cnt_reg   <= '0;
      asm_reg   <= '0;
      valm_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg  <= req_addr[AW-1:0];
            wdata_reg <= req_data[WW-1:0];
            rd_reg    <= is_rd;
            cnt_reg   <= '0;
            asm_reg   <= '0;
            if (!is_mem) begin
              err_reg <= 1'b0;
            end else if (!addr_ok) begin
              err_reg <= 1'b1;
              if (is_rd) valm_reg <= '0;
            end
          end
        end
        ACCESS: begin
          if (rd_reg) asm_reg <= asm_next;
          if (last_byte) begin
            err_reg <= 1'b0;
            if (rd_reg) valm_reg <= DATA_W'(asm_next);
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign valM       = valm_reg;
  assign dmem_error = err_reg;

endmodule

// File: tb/tb_y86_dmem_seq_unit.sv
// Self-checking bench for y86_dmem_seq_unit: byte-level memory model plus a
// scoreboard of expected (valM, dmem_error, latency) per request.
module tb_y86_dmem_seq_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP, valM;
  logic        busy, done, dmem_error;

  always #5 clk = ~clk;

  y86_dmem_seq_unit #(.MEM_BYTES(1024), .WORD_BYTES(8), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  model_mem [1024];
  logic [63:0] model_valm;

  typedef struct {
    logic [63:0] valm;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Drive one request, predict its result into the scoreboard, then wait for done and compare.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input bit hold, input string name);
    bit          is_mem, is_rd, legal, busy_ok;
    logic [63:0] addr, data;
    logic [64:0] addr_end;
    exp_t        ex, got;
    int          lat;
    is_mem = 1'b0; is_rd = 1'b0; addr = e; data = a;
    case (ic)
      4'h4: is_mem = 1'b1;
      4'h5: begin is_mem = 1'b1; is_rd = 1'b1; end
      4'h8: begin is_mem = 1'b1; data = p; end
      4'h9: begin is_mem = 1'b1; is_rd = 1'b1; addr = a; end
      4'hA: is_mem = 1'b1;
      4'hB: begin is_mem = 1'b1; is_rd = 1'b1; addr = a; end
      default: ;
    endcase
    addr_end = {1'b0, addr} + 65'd8;
    legal    = is_mem && (addr_end <= 65'd1024);
    if (legal) begin
      for (int k = 0; k < 8; k++) begin
        if (is_rd) model_valm[8*k +: 8] = model_mem[int'(addr[9:0]) + k];
        else       model_mem[int'(addr[9:0]) + k] = data[8*k +: 8];
      end
      ex.lat = 9; ex.err = 1'b0;
    end else if (is_mem) begin
      ex.lat = 1; ex.err = 1'b1;
      if (is_rd) model_valm = '0;
    end else begin
      ex.lat = 1; ex.err = 1'b0;
    end
    ex.valm = model_valm;
    sb.push_back(ex);

    @(posedge clk); #1;
    start = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    @(posedge clk); #1;
    start = hold;
    icode = hold ? 4'h4 : 4'($urandom);
    valE  = {$urandom, $urandom} & 64'h1F8;
    valA  = {$urandom, $urandom};
    valP  = {$urandom, $urandom};
    lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    got = sb.pop_front();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen after %0d cycles", name, lat);
    end else begin
      n_checks++;
      if (valM !== got.valm) begin
        n_fail++;
        $display("FAIL %s valM: got %h expected %h", name, valM, got.valm);
      end
      n_checks++;
      if (dmem_error !== got.err) begin
        n_fail++;
        $display("FAIL %s dmem_error: got %b expected %b", name, dmem_error, got.err);
      end
      n_checks++;
      if (lat != got.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, got.lat);
      end
      n_checks++;
      if (!busy_ok) begin
        n_fail++;
        $display("FAIL %s busy: dropped before done, expected high throughout", name);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
    $display("op %s icode=%h valM=%h err=%b lat=%0d", name, ic, valM, dmem_error, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    n_checks++;
    if (valM !== 64'h0) begin n_fail++; $display("FAIL reset valM: got %h expected 0", valM); end
    n_checks++;
    if (dmem_error !== 1'b0) begin n_fail++; $display("FAIL reset dmem_error: got %b expected 0", dmem_error); end
    reset = 1'b0;
    model_valm = '0;
    $display("reset checked busy=%b done=%b valM=%h err=%b", busy, done, valM, dmem_error);
  endtask

  task automatic test_read();
    run_op(4'h5, 64'd16, 64'h0, 64'h0, 1'b0, "mrmovq_16");
    n_checks++;
    if (valM !== 64'h17161514_13121110) begin
      n_fail++; $display("FAIL read_16_const valM: got %h expected 1716151413121110", valM);
    end
  endtask

  task automatic test_write_readback();
    run_op(4'h4, 64'd100, 64'h11223344_55667788, 64'h0, 1'b0, "rmmovq_100");
    run_op(4'h5, 64'd100, 64'h0, 64'h0, 1'b0, "mrmovq_100");
    n_checks++;
    if (valM !== 64'h11223344_55667788) begin
      n_fail++; $display("FAIL readback_100_const valM: got %h expected 1122334455667788", valM);
    end
    run_op(4'h5, 64'd104, 64'h0, 64'h0, 1'b0, "mrmovq_104");
  endtask

  task automatic test_stack();
    run_op(4'hA, 64'd200, 64'hDEAD, 64'h0, 1'b0, "pushq_200");
    run_op(4'hB, 64'd0, 64'd200, 64'h0, 1'b0, "popq_200");
    n_checks++;
    if (valM !== 64'hDEAD) begin n_fail++; $display("FAIL popq_const valM: got %h expected dead", valM); end
    run_op(4'h8, 64'd300, 64'h5555, 64'h40, 1'b0, "call_300");
    run_op(4'h9, 64'd8, 64'd300, 64'h0, 1'b0, "ret_300");
    n_checks++;
    if (valM !== 64'h40) begin n_fail++; $display("FAIL ret_const valM: got %h expected 40", valM); end
  endtask

  task automatic test_boundary();
    run_op(4'h5, 64'd1016, 64'h0, 64'h0, 1'b0, "mrmovq_1016");
    n_checks++;
    if (valM !== 64'hFFFEFDFC_FBFAF9F8) begin
      n_fail++; $display("FAIL top_word_const valM: got %h expected fffefdfcfbfaf9f8", valM);
    end
    run_op(4'h5, 64'd1020, 64'h0, 64'h0, 1'b0, "mrmovq_1020");
    run_op(4'h4, 64'd1020, 64'h0, 64'h0, 1'b0, "rmmovq_1020");
    run_op(4'hA, 64'd1017, 64'h1234, 64'h0, 1'b0, "pushq_1017");
    run_op(4'h5, 64'd1016, 64'h0, 64'h0, 1'b0, "mrmovq_1016_again");
    run_op(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b0, "mrmovq_wrap");
    run_op(4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h77, 64'h0, 1'b0, "rmmovq_wrap");
    run_op(4'h9, 64'd0, 64'd1016, 64'h0, 1'b0, "ret_1016");
    run_op(4'h5, 64'd0, 64'h0, 64'h0, 1'b0, "mrmovq_0");
  endtask

  task automatic test_nonmem();
    run_op(4'h1, 64'd16, 64'h99, 64'h0, 1'b0, "nop");
    run_op(4'hF, 64'd5000, 64'h99, 64'h0, 1'b0, "icode_f");
    run_op(4'h7, 64'd24, 64'h99, 64'h0, 1'b0, "jxx");
  endtask

  task automatic test_busy_ignore();
    bit extra;
    run_op(4'h4, 64'd500, 64'hA1A2A3A4_A5A6A7A8, 64'h0, 1'b1, "rmmovq_500_hold");
    run_op(4'h5, 64'd16, 64'h0, 64'h0, 1'b1, "mrmovq_16_hold");
    extra = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
    end
    n_checks++;
    if (extra) begin n_fail++; $display("FAIL busy_ignore extra_done: got activity expected none"); end
    run_op(4'h5, 64'd496, 64'h0, 64'h0, 1'b0, "mrmovq_496");
    run_op(4'h5, 64'd504, 64'h0, 64'h0, 1'b0, "mrmovq_504");
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; icode = 4'h4; valE = 64'd400; valA = 64'h08070605_04030201; valP = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid state: got busy=%b done=%b expected 0 0", busy, done);
    end
    reset = 1'b0;
    model_mem[400] = 8'h01; model_mem[401] = 8'h02; model_mem[402] = 8'h03;
    model_valm = '0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL reset_mid done: got pulse expected none"); end
    $display("reset_mid busy=%b done_seen=%b", busy, seen);
    run_op(4'h5, 64'd400, 64'h0, 64'h0, 1'b0, "mrmovq_400");
    n_checks++;
    if (valM !== 64'h97969594_93030201) begin
      n_fail++; $display("FAIL reset_mid_const valM: got %h expected 9796959493030201", valM);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'(i % 256);
    model_valm = '0;
    test_reset();
    test_read();
    test_write_readback();
    test_stack();
    test_boundary();
    test_nonmem();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
